// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the RV32 fetch front end: controller next-PC codes,
// fetch FSM encodings, the NOP word and the next-PC request payload.
// Build option: NPC_ALIGN_CHECK_EN adds the S_HALT state.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NPC_OP_W  = 2;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned FUNCT7_W  = 7;

    // Next-PC operation codes, shared with the controller
    localparam logic [NPC_OP_W-1:0] NPC_OP_PC_4    = 2'd0;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BR      = 2'd1;
    localparam logic [NPC_OP_W-1:0] NPC_OP_OFFSET  = 2'd2;
    localparam logic [NPC_OP_W-1:0] NPC_OP_NODOING = 2'd3;

    // PC source select, shared with the controller
    localparam logic PC_SEL_NPC = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INST_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3
`ifdef NPC_ALIGN_CHECK_EN
        ,
        S_HALT  = 3'd4
`endif
    } state_e;

    // Everything the controller/ALU supply to pick the next PC
    typedef struct packed {
        logic [NPC_OP_W-1:0] npc_op;
        logic                pc_sel;
        logic                br_taken;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     alu_c;
    } npc_in_t;

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Ports: pc (current PC), npc_in (controller/ALU payload), target_c (raw
// next PC; low two bits are left for the caller to check or clear).
module pc_fetch_unit_npc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  npc_in_t         npc_in,
    output logic [XLEN-1:0] target_c
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;

    // Both adders wrap at 32 bits; the carry is dropped on purpose
    assign pc_plus4    = pc + XLEN'(4);
    assign pc_plus_imm = pc + npc_in.imm;

    // jalr target clears bit 0 and overrides npc_op
    always_comb begin
        target_c = pc_plus4;
        if (npc_in.pc_sel == PC_SEL_ALU) begin
            target_c = npc_in.alu_c & ~XLEN'(1);
        end else begin
            case (npc_in.npc_op)
                NPC_OP_BR:     target_c = npc_in.br_taken ? pc_plus_imm : pc_plus4;
                NPC_OP_OFFSET: target_c = pc_plus_imm;
                default:       target_c = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32 fetch front end: holds the PC, fetches one instruction at a time over
// a req/gnt/rvalid port, presents it to decode and advances the PC on retire.
// Ports: clk/rst (sync active-high); imem_* fetch port; inst_valid, inst,
// opcode/funct3/funct7, pc, pc4 to decode; inst_ack plus next-PC inputs
// (npc_op, pc_sel, br_taken, imm, alu_c) from the core; instret counter.
// Build option NPC_ALIGN_CHECK_EN: a misaligned next PC on retire raises a
// sticky misalign output and parks the unit in S_HALT until reset; without
// it the target's low two bits are cleared.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic                inst_valid,
    output logic [XLEN-1:0]     inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT3_W-1:0] funct3,
    output logic [FUNCT7_W-1:0] funct7,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc4,
    input  logic                inst_ack,
    input  logic [NPC_OP_W-1:0] npc_op,
    input  logic                pc_sel,
    input  logic                br_taken,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     alu_c,
`ifdef NPC_ALIGN_CHECK_EN
    output logic                misalign,
`endif
    output logic [XLEN-1:0]     instret
);

    state_e          state;
    state_e          state_nxt;
    npc_in_t         npc_in;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic            inst_load;
    logic            retire;
    logic            halt_set;

    assign npc_in = '{npc_op: npc_op, pc_sel: pc_sel, br_taken: br_taken,
                      imm: imm, alu_c: alu_c};

    pc_fetch_unit_npc_calc u_npc_calc (
        .pc       (pc),
        .npc_in   (npc_in),
        .target_c (target_raw)
    );

`ifdef NPC_ALIGN_CHECK_EN
    assign target = target_raw;
`else
    assign target = target_raw & ~XLEN'(3);
`endif

    // Decode fields are plain slices of the instruction register
    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];
    assign imem_addr = pc;

    // Next-state and datapath strobes
    always_comb begin
        state_nxt = state;
        inst_load = 1'b0;
        retire    = 1'b0;
        halt_set  = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_load = 1'b1;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ack) begin
`ifdef NPC_ALIGN_CHECK_EN
                    if (target[1:0] != 2'b00) begin
                        halt_set  = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_REQ;
                    end
`else
                    retire    = 1'b1;
                    state_nxt = S_REQ;
`endif
                end
            end
`ifdef NPC_ALIGN_CHECK_EN
            S_HALT:  state_nxt = S_HALT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, registered handshake outputs, PC, instruction and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            pc         <= RESET_PC;
            pc4        <= RESET_PC + XLEN'(4);
            inst       <= NOP_INST;
            instret    <= '0;
`ifdef NPC_ALIGN_CHECK_EN
            misalign   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            imem_req   <= (state_nxt == S_REQ);
            inst_valid <= (state_nxt == S_VALID);
            if (inst_load) begin
                inst <= imem_rdata;
            end else if (retire || halt_set) begin
                inst <= NOP_INST;
            end
            if (retire) begin
                pc      <= target;
                pc4     <= target + XLEN'(4);
                instret <= instret + XLEN'(1);
            end
`ifdef NPC_ALIGN_CHECK_EN
            if (halt_set) begin
                misalign <= 1'b1;
            end
`endif
        end
    end

endmodule
